// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: frame constants, line level and FSM states.
package uart_pkg;

  localparam int unsigned DATA_BITS             = 8;
  localparam int unsigned DEFAULT_TICKS_PER_BIT = 16;
  localparam logic        LINE_IDLE             = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push into a full FIFO is refused
// even when a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned Aw = $clog2(Depth);

  logic [Aw:0]      wr_ptr_q, rd_ptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  // Same index with differing wrap bit means the write pointer lapped the read pointer.
  assign full    = (wr_ptr_q[Aw] != rd_ptr_q[Aw]) && (wr_ptr_q[Aw-1:0] == rd_ptr_q[Aw-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[Aw-1:0]];

  // Pointer update; reset empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (Aw+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (Aw+1)'(1);
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[Aw-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: bytes queue in a small FIFO and are shifted out
// LSB first, each bit lasting TICKS_PER_BIT asserted ticks.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned TICKS_PER_BIT = DEFAULT_TICKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 send,
  output logic                 ready,
  output logic                 bit_out,
  output logic                 busy,
  output logic                 sent
);

  localparam int unsigned Cw = $clog2(TICKS_PER_BIT);
  localparam int unsigned Iw = $clog2(DATA_BITS);

  tx_state_e            state_q;
  logic [Cw-1:0]        tick_cnt_q;
  logic [Iw-1:0]        bit_idx_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full, fifo_empty, fifo_pop;
  logic                 bit_end;

  uart_tx_fifo #(
    .Width (DATA_BITS),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (send),
    .wdata (data_in),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The tick that closes the current bit time.
  assign bit_end  = tick && (tick_cnt_q == Cw'(TICKS_PER_BIT - 1));
  // Pop from idle, or straight out of a finishing stop bit so frames run back to back.
  assign fifo_pop = !fifo_empty && ((state_q == StIdle) || ((state_q == StStop) && bit_end));
  assign ready    = !fifo_full;

  // Frame sequencer with registered line, busy and sent outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      bit_out    <= LINE_IDLE;
      busy       <= 1'b0;
      sent       <= 1'b0;
    end else begin
      sent <= 1'b0;
      if ((state_q != StIdle) && tick) begin
        tick_cnt_q <= bit_end ? '0 : tick_cnt_q + Cw'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (fifo_pop) begin
            shreg_q    <= fifo_rdata;
            tick_cnt_q <= '0;
            bit_out    <= 1'b0;
            busy       <= 1'b1;
            state_q    <= StStart;
          end
        end
        StStart: begin
          if (bit_end) begin
            bit_idx_q <= '0;
            bit_out   <= shreg_q[0];
            state_q   <= StData;
          end
        end
        StData: begin
          if (bit_end) begin
            bit_idx_q <= bit_idx_q + Iw'(1);
            if (bit_idx_q == Iw'(DATA_BITS - 1)) begin
              bit_out <= LINE_IDLE;
              state_q <= StStop;
            end else begin
              bit_out <= shreg_q[1];
              shreg_q <= shreg_q >> 1;
            end
          end
        end
        StStop: begin
          if (bit_end) begin
            sent <= 1'b1;
            if (fifo_pop) begin
              shreg_q <= fifo_rdata;
              bit_out <= 1'b0;
              state_q <= StStart;
            end else begin
              busy    <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a tick-counting serial receiver model decodes
// bit_out and compares each frame against a queue of expected bytes.
module tb_uart_tx;

  localparam int unsigned Tpb = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b1;
  logic       send = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       ready, bit_out, busy, sent;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         tick_mode = 1;  // 0: low, 1: high, 2: one tick every 4 clk
  int         div_cnt = 0;
  bit         mon_en = 1'b1;
  bit         mon_busy = 1'b0;

  always #5 clk = ~clk;

  uart_tx #(
    .TICKS_PER_BIT (Tpb),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .data_in (data_in),
    .send    (send),
    .ready   (ready),
    .bit_out (bit_out),
    .busy    (busy),
    .sent    (sent)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Tick driver; updates a little after the edge so it never races the stimulus.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (tick_mode == 2) begin
        div_cnt++;
        tick = ((div_cnt % 4) == 3);
      end else begin
        tick = (tick_mode == 1);
      end
    end
  end

  // Receiver model: bit times are counted in asserted ticks, sampled mid-bit.
  initial begin : rx_model
    int         tcnt;
    int         idx;
    logic [7:0] rx_byte;
    forever begin
      @(negedge clk);
      while (mon_en && !rst && bit_out == 1'b0) begin
        mon_busy = 1'b1;
        tcnt     = 0;
        rx_byte  = 8'h00;
        while (tcnt < 10 * Tpb) begin
          if (tick) begin
            if ((tcnt % Tpb) == Tpb / 2) begin
              idx = tcnt / Tpb;
              if (idx == 0)      check("rx_start_bit", bit_out, 1'b0);
              else if (idx == 9) check("rx_stop_bit", bit_out, 1'b1);
              else               rx_byte[idx-1] = bit_out;
            end
            tcnt++;
          end
          @(negedge clk);
        end
        check("rx_frame_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) check("rx_byte", rx_byte, exp_q.pop_front());
        mon_busy = 1'b0;
      end
    end
  end

  // Drive one send cycle; exp_acc is the bench's own prediction of ready.
  task automatic push_byte(input logic [7:0] b, input bit exp_acc, input bit track);
    data_in = b;
    send    = 1'b1;
    check($sformatf("ready_at_push_%02h", b), ready, exp_acc);
    if (exp_acc && track) exp_q.push_back(b);
    @(posedge clk);
    #1;
    send = 1'b0;
  endtask

  // Returns at the negedge of the first start-bit cycle.
  task automatic wait_fall(input string tag);
    int n = 0;
    @(negedge clk);
    while (bit_out !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, bit_out, 1'b0);
  endtask

  task automatic drain(input int bound, input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < bound) begin
      @(posedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int         errs, busy_errs, sent_errs, idx, nsent, drops, n, first_change;
    logic       expv;
    logic [7:0] pat;

    // Reset state, asserted between edges to show it is asynchronous.
    #2 rst = 1'b1;
    #1;
    check("reset_bit_out", bit_out, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_sent", sent, 1'b0);
    check("reset_ready", ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single 0x55 frame: exact line shape, busy and sent timing.
    pat = 8'h55;
    push_byte(pat, 1'b1, 1'b1);
    wait_fall("t1_start_fall");
    errs = 0; busy_errs = 0; sent_errs = 0;
    for (int s = 0; s < 160; s++) begin
      idx  = s / 16;
      expv = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : pat[idx-1];
      if (bit_out !== expv) errs++;
      if (busy !== 1'b1) busy_errs++;
      if (sent !== 1'b0) sent_errs++;
      @(negedge clk);
    end
    check("t1_line_shape_errs", errs, 0);
    check("t1_busy_errs", busy_errs, 0);
    check("t1_early_sent", sent_errs, 0);
    check("t1_sent_at_160", sent, 1'b1);
    check("t1_busy_after", busy, 1'b0);
    drain(400, "t1_drain");

    // Back-to-back frames: next start bit begins with the sent pulse, busy holds.
    push_byte(8'hA5, 1'b1, 1'b1);
    push_byte(8'h3C, 1'b1, 1'b1);
    wait_fall("t2_start_fall");
    nsent = 0; drops = 0; n = 0;
    while (nsent < 2 && n < 400) begin
      if (sent) begin
        nsent++;
        if (nsent == 1) check("t2_second_start_low", bit_out, 1'b0);
      end
      if (nsent < 2 && !busy) drops++;
      @(negedge clk);
      n++;
    end
    check("t2_sent_pulses", nsent, 2);
    check("t2_busy_drops", drops, 0);
    drain(400, "t2_drain");

    // Line stalled: FIFO fills with 02..05 after 01 is taken, sixth push refused.
    tick_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 1; i <= 5; i++) push_byte(8'(i), 1'b1, 1'b1);
    push_byte(8'h06, 1'b0, 1'b1);
    check("t3_busy_stalled", busy, 1'b1);
    check("t3_line_in_start", bit_out, 1'b0);
    check("t3_ready_full", ready, 1'b0);
    tick_mode = 1;
    drain(3000, "t3_drain");

    // One tick every 4 clk: 64 clk per bit, 640 clk per frame.
    tick_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    push_byte(8'h69, 1'b1, 1'b1);
    wait_fall("t4_start_fall");
    div_cnt = 0;
    tick_mode = 2;
    n = 0; first_change = -1;
    while (!sent && n < 800) begin
      if (first_change < 0 && bit_out !== 1'b0) first_change = n;
      @(negedge clk);
      n++;
    end
    check("t4_start_bit_len", first_change, 64);
    check("t4_frame_len", n, 640);
    tick_mode = 1;
    drain(800, "t4_drain");

    // Reset in data bit 3 of 0xF0 with another byte queued: both discarded.
    mon_en = 1'b0;
    push_byte(8'hF0, 1'b1, 1'b0);
    push_byte(8'h11, 1'b1, 1'b0);
    wait_fall("t5_start_fall");
    repeat (72) @(negedge clk);
    check("t5_line_in_bit3", bit_out, 1'b0);
    rst = 1'b1;
    #1;
    check("t5_reset_line_high", bit_out, 1'b1);
    check("t5_reset_busy", busy, 1'b0);
    check("t5_reset_ready", ready, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    nsent = 0; drops = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sent) nsent++;
      if (!bit_out) drops++;
    end
    check("t5_no_sent_after_reset", nsent, 0);
    check("t5_line_idle_after_reset", drops, 0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    push_byte(8'h81, 1'b1, 1'b1);
    drain(400, "t5_drain");

    // Loopback into the receiver model.
    push_byte(8'hC3, 1'b1, 1'b1);
    drain(400, "t6_drain");
    check("t6_idle_busy", busy, 1'b0);
    check("t6_idle_line", bit_out, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
